// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        cls;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, cls, rd, rs1, rs2, funct3, funct7, imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, cls, rd, rs1, rs2, funct3, funct7, imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Builds RV32I LOAD/STORE/R-type/BRANCH words from fields and streams them
// into instruction memory, one word per accepted bundle.
module instr_encoder #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    instr_encoder_if.slave   bus,
    output logic             err,
    output logic [CNT_W-1:0] words_written
);
    typedef enum logic { IDLE, WRITE } state_t;

    localparam logic [1:0] CLS_LOAD   = 2'b00;
    localparam logic [1:0] CLS_STORE  = 2'b01;
    localparam logic [1:0] CLS_RTYPE  = 2'b10;
    localparam logic [1:0] CLS_BRANCH = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  count;
    logic [31:0]       enc;
    logic              legal;
    logic signed [31:0] simm;

    assign simm = $signed(bus.imm);

    // Range checks run on the full 32-bit value so out-of-range immediates
    // cannot alias into a legal-looking low field.
    always_comb begin
        enc   = 32'd0;
        legal = 1'b1;
        case (bus.cls)
            CLS_LOAD: begin
                enc   = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_LOAD};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            CLS_STORE: begin
                enc   = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OP_STORE};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            CLS_RTYPE: begin
                enc   = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_RTYPE};
                legal = 1'b1;
            end
            CLS_BRANCH: begin
                enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                         bus.imm[4:1], bus.imm[11], OP_BRANCH};
                legal = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !bus.imm[0];
            end
            default: begin
                enc   = 32'd0;
                legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= ADDR_W'(BASE_ADDR);
            count   <= '0;
            wdata_q <= 32'd0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart) begin
                        addr_q <= ADDR_W'(BASE_ADDR);
                        count  <= '0;
                    end else if (bus.in_valid) begin
                        if (legal) begin
                            wdata_q <= enc;
                            state   <= WRITE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // restart is deliberately not looked at here: the write completes
                    if (bus.mem_ready) begin
                        addr_q <= addr_q + ADDR_W'(4);
                        count  <= count + CNT_W'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !restart && !rst;
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign words_written = count;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, addressing, backpressure,
// illegal bundles, restart and reset.
module tb_instr_encoder;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             restart;
    logic             err;
    logic [CNT_W-1:0] words_written;
    int               checks = 0;
    int               errors = 0;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .restart       (restart),
        .bus           (bus.slave),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] c, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
        bus.cls = c; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = im;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Handshake, check the write beat, then commit with mem_ready=1.
    task automatic wr(input string tag, input logic [1:0] c, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] exp_word, input logic [31:0] exp_addr,
                      input logic [31:0] exp_cnt);
        put(c, d, s1, s2, f3, f7, im);
        chk({tag, "_we"},    32'(bus.mem_we), 32'd1);
        chk({tag, "_addr"},  32'(bus.mem_addr), exp_addr);
        chk({tag, "_wdata"}, bus.mem_wdata, exp_word);
        chk({tag, "_rdy"},   32'(bus.in_ready), 32'd0);
        step();
        chk({tag, "_we_off"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_cnt"},    32'(words_written), exp_cnt);
        chk({tag, "_next"},   32'(bus.mem_addr), exp_addr + 32'd4);
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0;
        bus.in_valid = 1'b0; bus.mem_ready = 1'b1;
        bus.cls = 2'b00; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        step(); step();
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        chk("rst_rdy",   32'(bus.in_ready), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_cnt",   32'(words_written), 32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_rdy", 32'(bus.in_ready), 32'd1);

        wr("load",   2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8,  32'h00812283, 32'h000, 32'd1);
        wr("store",  2'b01, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd12, 32'h00512623, 32'h004, 32'd2);
        wr("rtype",  2'b10, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,  32'h002081B3, 32'h008, 32'd3);
        wr("branch", 2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd8, 32'hFE208CE3, 32'h00C, 32'd4);

        // Stalled write of LOAD imm=-2048; restart during the stall must be ignored.
        bus.mem_ready = 1'b0;
        put(2'b00, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2048);
        for (int i = 0; i < 3; i++) begin
            restart = (i == 1);
            chk("bp_we",    32'(bus.mem_we), 32'd1);
            chk("bp_addr",  32'(bus.mem_addr), 32'h010);
            chk("bp_wdata", bus.mem_wdata, 32'h80000003);
            chk("bp_rdy",   32'(bus.in_ready), 32'd0);
            chk("bp_cnt",   32'(words_written), 32'd4);
            step();
        end
        restart = 1'b0;
        bus.mem_ready = 1'b1;
        chk("bp_hold_we", 32'(bus.mem_we), 32'd1);
        step();
        chk("bp_done_we",   32'(bus.mem_we), 32'd0);
        chk("bp_done_cnt",  32'(words_written), 32'd5);
        chk("bp_done_addr", 32'(bus.mem_addr), 32'h014);

        // Illegal bundles: one-cycle err pulse, nothing written.
        put(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
        chk("br_odd_err",  32'(err), 32'd1);
        chk("br_odd_we",   32'(bus.mem_we), 32'd0);
        chk("br_odd_addr", 32'(bus.mem_addr), 32'h014);
        chk("br_odd_rdy",  32'(bus.in_ready), 32'd1);
        step();
        chk("br_odd_pulse", 32'(err), 32'd0);
        put(2'b00, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd2048);
        chk("ld_big_err", 32'(err), 32'd1);
        chk("ld_big_we",  32'(bus.mem_we), 32'd0);
        step();
        chk("ld_big_cnt", 32'(words_written), 32'd5);
        put(2'b01, 5'd0, 5'd1, 5'd0, 3'b000, 7'd0, 32'h0000_1000);
        chk("st_big_err", 32'(err), 32'd1);
        put(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096);
        chk("br_big_err", 32'(err), 32'd1);
        chk("br_big_we",  32'(bus.mem_we), 32'd0);
        step();

        // Restart in IDLE blocks acceptance and reloads address/count.
        restart = 1'b1;
        bus.in_valid = 1'b1;
        bus.cls = 2'b10;
        #1;
        chk("rs_rdy", 32'(bus.in_ready), 32'd0);
        step();
        restart = 1'b0;
        bus.in_valid = 1'b0;
        chk("rs_addr", 32'(bus.mem_addr), 32'h000);
        chk("rs_cnt",  32'(words_written), 32'd0);
        chk("rs_we",   32'(bus.mem_we), 32'd0);

        // Reset mid-write drops the pending word.
        bus.mem_ready = 1'b0;
        put(2'b10, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
        chk("mid_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        chk("mid_rst_we",   32'(bus.mem_we), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'h000);
        chk("mid_rst_cnt",  32'(words_written), 32'd0);
        step();
        chk("mid_rst_we2",  32'(bus.mem_we), 32'd0);
        chk("mid_rst_cnt2", 32'(words_written), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
